// File: rtl/uart_tx.sv
// UART transmitter: start bit, N_BITS data LSB first, SB_TICK-tick stop period, 16 ticks per bit.
// tx low on the accepting edge; tx_start is ignored while busy, so there is no queuing.
module uart_tx #(
  parameter int N_BITS  = 8,
  parameter int SB_TICK = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  input  logic              tx_start,
  input  logic [N_BITS-1:0] din,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int S_MAX = (SB_TICK - 1 > 15) ? SB_TICK - 1 : 15;
  localparam int S_W   = $clog2(S_MAX + 1);
  localparam int N_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [S_W-1:0]    s_q, s_d;
  logic [N_W-1:0]    n_q, n_d;
  logic [N_BITS-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          shift_d = din;
          s_d     = '0;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == S_W'(15)) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
            tx_d    = shift_q[0];
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == S_W'(15)) begin
            s_d     = '0;
            shift_d = shift_q >> 1;
            if (n_q == N_W'(N_BITS - 1)) begin
              state_d = STOP;
              tx_d    = 1'b1;
            end else begin
              n_d  = n_q + N_W'(1);
              // next LSB is bit 1 of the pre-shift word
              tx_d = shift_q[1];
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == S_W'(SB_TICK - 1)) begin
            s_d     = '0;
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 and 2 stop bits) against a tick-count frame model
// plus a line decoder and literal latency/data expectations.
module tb_uart_tx;
  localparam int N = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tx0, busy0, done0, tx1, busy1, done1;

  always #5 clock = ~clock;

  uart_tx #(.N_BITS(8), .SB_TICK(16)) dut0 (
    .clock(clock), .reset(reset), .tick(tick), .tx_start(tx_start), .din(din),
    .tx(tx0), .busy(busy0), .tx_done(done0));
  uart_tx #(.N_BITS(8), .SB_TICK(32)) dut1 (
    .clock(clock), .reset(reset), .tick(tick), .tx_start(tx_start), .din(din),
    .tx(tx1), .busy(busy1), .tx_done(done1));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int tick_mode = 1;   // 0: every 4 clocks, 1: random, 2: frozen low
  int tdiv = 0;
  bit chk_en = 1'b0;

  always @(posedge clock) begin
    #1;
    tdiv = (tdiv + 1) % 4;
    case (tick_mode)
      0:       tick = (tdiv == 0);
      1:       tick = ($urandom_range(0, 2) == 0);
      default: tick = 1'b0;
    endcase
  end

  // Frame model: a frame is just a count of ticks since acceptance.
  bit         m_busy[2];
  bit         m_done[2];
  int         m_cnt[2];
  logic [7:0] m_word[2];
  int         flen[2] = '{16 * (N + 1) + 16, 16 * (N + 1) + 32};

  always @(posedge clock) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (reset) begin
        m_busy[i] = 1'b0;
        m_cnt[i]  = 0;
      end else if (!m_busy[i]) begin
        if (tx_start) begin
          m_busy[i] = 1'b1;
          m_cnt[i]  = 0;
          m_word[i] = din;
        end
      end else if (tick) begin
        m_cnt[i]++;
        if (m_cnt[i] == flen[i]) begin
          m_busy[i] = 1'b0;
          m_done[i] = 1'b1;
        end
      end
    end
  end

  function automatic logic exp_tx(input int i);
    if (!m_busy[i]) return 1'b1;
    if (m_cnt[i] < 16) return 1'b0;
    if (m_cnt[i] < 16 * (N + 1)) return m_word[i][m_cnt[i] / 16 - 1];
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("tx0", {31'd0, tx0}, {31'd0, exp_tx(0)});
      chk("busy0", {31'd0, busy0}, {31'd0, m_busy[0]});
      chk("done0", {31'd0, done0}, {31'd0, m_done[0]});
      chk("busy_and_done0", {31'd0, busy0 & done0}, 32'd0);
      chk("tx1", {31'd0, tx1}, {31'd0, exp_tx(1)});
      chk("busy1", {31'd0, busy1}, {31'd0, m_busy[1]});
      chk("done1", {31'd0, done1}, {31'd0, m_done[1]});
      chk("busy_and_done1", {31'd0, busy1 & done1}, 32'd0);
    end
  end

  // Line decoder: samples mid-bit by counting ticks from the start-bit falling edge.
  bit         dact[2];
  int         dc[2];
  logic [7:0] dw[2];
  logic [7:0] rxq0[$];
  logic [7:0] rxq1[$];

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      logic t;
      t = (i == 0) ? tx0 : tx1;
      if (reset) begin
        dact[i] = 1'b0;
      end else begin
        if (!dact[i] && t === 1'b0) begin
          dact[i] = 1'b1;
          dc[i]   = 0;
        end
        if (dact[i] && tick) begin
          dc[i]++;
          if (dc[i] % 16 == 8 && dc[i] > 16 && dc[i] < 16 * (N + 1))
            dw[i][dc[i] / 16 - 1] = t;
          if (dc[i] == 16 * (N + 1) + 8) begin
            if (i == 0) rxq0.push_back(dw[i]);
            else        rxq1.push_back(dw[i]);
            dact[i] = 1'b0;
          end
        end
      end
    end
  end

  // Observed acceptance / completion timing.
  bit pb[2];
  int rise_cyc[2];
  int done_cyc[2];
  int done_cnt[2];
  int lat[2];

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      logic b, d;
      b = (i == 0) ? busy0 : busy1;
      d = (i == 0) ? done0 : done1;
      if (b === 1'b1 && !pb[i]) rise_cyc[i] = cyc;
      if (d === 1'b1) begin
        done_cnt[i]++;
        done_cyc[i] = cyc;
        lat[i]      = cyc - rise_cyc[i];
      end
      pb[i] = (b === 1'b1);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_done(input int i, input int budget, input string nm);
    int d0;
    d0 = done_cnt[i];
    for (int k = 0; k < budget; k++) begin
      step(1);
      if (done_cnt[i] != d0) return;
    end
    total++;
    bad++;
    $display("FAIL %s: no tx_done within %0d cycles", nm, budget);
  endtask

  task automatic chk_rx(input int i, input logic [7:0] exp, input string nm);
    logic [7:0] w;
    int sz;
    sz = (i == 0) ? rxq0.size() : rxq1.size();
    total++;
    if (sz == 0) begin
      bad++;
      $display("FAIL %s: no frame decoded, want %0h", nm, exp);
      return;
    end
    if (i == 0) w = rxq0.pop_front();
    else        w = rxq1.pop_front();
    if (w !== exp) begin
      bad++;
      $display("FAIL %s: decoded %0h want %0h", nm, w, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] d);
    din      = d;
    tx_start = 1'b1;
    step(1);
    tx_start = 1'b0;
    din      = 8'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dref0, dref1;
    // Reset with tick toggling and tx_start held high
    tx_start = 1'b1;
    din      = 8'h55;
    step(1);
    chk_en = 1'b1;
    step(2);
    chk("rst_tx", {31'd0, tx0}, 32'd1);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    reset    = 1'b0;
    tx_start = 1'b0;
    step(6);
    chk("idle_tx", {31'd0, tx0}, 32'd1);
    chk("idle_busy1", {31'd0, busy1}, 32'd0);

    // Single frame 0xA5 at one tick per 4 clocks
    tick_mode = 0;
    step(3);
    pulse(8'hA5);
    chk("accept_tx_low", {31'd0, tx0}, 32'd0);
    chk("accept_busy", {31'd0, busy0}, 32'd1);
    wait_done(0, 800, "a5_done0");
    chk_rng("a5_lat0", lat[0], 637, 643);
    chk_rx(0, 8'hA5, "a5_rx0");
    wait_done(1, 200, "a5_done1");
    chk_rng("a5_lat1", lat[1], 701, 707);
    chk_rx(1, 8'hA5, "a5_rx1");

    // Request while busy is ignored
    step(5);
    dref0 = done_cnt[0];
    dref1 = done_cnt[1];
    pulse(8'hA5);
    step(4 * 64);
    pulse(8'hFF);
    wait_done(0, 800, "rej_done0");
    wait_done(1, 200, "rej_done1");
    step(50);
    chk("rej_one_done0", done_cnt[0] - dref0, 32'd1);
    chk("rej_one_done1", done_cnt[1] - dref1, 32'd1);
    chk("rej_idle", {31'd0, busy0}, 32'd0);
    chk_rx(0, 8'hA5, "rej_rx0");
    chk_rx(1, 8'hA5, "rej_rx1");

    // Back-to-back with tx_start held high
    din      = 8'h00;
    tx_start = 1'b1;
    step(1);
    din = 8'hFF;
    wait_done(0, 800, "b2b_done0");
    step(2);
    tx_start = 1'b0;
    chk("b2b_gap", rise_cyc[0] - done_cyc[0], 32'd1);
    wait_done(1, 200, "b2b_done1");
    wait_done(0, 800, "b2b_done0b");
    chk_rx(0, 8'h00, "b2b_rx0a");
    chk_rx(0, 8'hFF, "b2b_rx0b");
    chk_rx(1, 8'h00, "b2b_rx1");

    // Tick stall mid-DATA (bit 2 of 0x3C is 1)
    step(5);
    pulse(8'h3C);
    step(64 * 3 + 20);
    tick_mode = 2;
    step(2);
    chk("stall_tx_pre", {31'd0, tx0}, 32'd1);
    step(200);
    chk("stall_tx_post", {31'd0, tx0}, 32'd1);
    chk("stall_busy", {31'd0, busy0}, 32'd1);
    tick_mode = 0;
    wait_done(0, 800, "stall_done0");
    wait_done(1, 200, "stall_done1");
    chk_rx(0, 8'h3C, "stall_rx0");
    chk_rx(1, 8'h3C, "stall_rx1");

    // Reset during bit 5, then a fresh 0x81 frame
    step(5);
    dref0 = done_cnt[0];
    dref1 = done_cnt[1];
    pulse(8'hF0);
    step(64 * 6 + 20);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("mrst_tx1", {31'd0, tx1}, 32'd1);
    chk("mrst_busy1", {31'd0, busy1}, 32'd0);
    chk("mrst_tx0", {31'd0, tx0}, 32'd1);
    step(300);
    chk("mrst_no_done0", done_cnt[0] - dref0, 32'd0);
    chk("mrst_no_done1", done_cnt[1] - dref1, 32'd0);
    pulse(8'h81);
    wait_done(0, 800, "x81_done0");
    wait_done(1, 200, "x81_done1");
    chk_rng("x81_lat1", lat[1], 701, 707);
    chk_rx(0, 8'h81, "x81_rx0");
    chk_rx(1, 8'h81, "x81_rx1");

    // Randomized ticks, words and requests; model checks every cycle
    tick_mode = 1;
    for (int k = 0; k < 12; k++) begin
      int w;
      for (int j = 0; j < 30; j++) begin
        tx_start = ($urandom_range(0, 3) == 0);
        din      = 8'($urandom);
        step(1);
      end
      tx_start = 1'b0;
      w = 0;
      while ((busy0 === 1'b1 || busy1 === 1'b1) && w < 3000) begin
        step(1);
        w++;
      end
      chk_rng("rand_idle_wait", w, 0, 2999);
    end

    step(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter and consumer of the baud tick from `baudrategen` (16x oversampling: 16 ticks per bit period).
- Serializes one N_BITS word per request as 1 start bit, N_BITS data bits LSB first, and a stop period of SB_TICK ticks.
- Provides a one-shot request input and a one-cycle completion pulse for the upstream interface/FIFO logic.

Parameters:
- N_BITS, 8, data bits per frame (range 5..9).
- SB_TICK, 16, stop period length in ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- clock, input, 1, system clock (50 MHz); all logic on the rising edge.
- reset, input, 1, synchronous, active-high; overrides all other inputs.
- tick, input, 1, one-clock-wide 16x baud strobe from `baudrategen`.
- tx_start, input, 1, transmit request; sampled only in IDLE.
- din, input, N_BITS, word to send; captured on the accepting edge.
- tx, output, 1, serial line; registered; idle high.
- busy, output, 1, high from the accepting edge until the frame ends.
- tx_done, output, 1, single-cycle pulse when the stop period completes.

Behaviour:
- Reset (any clock edge with reset=1): state IDLE, tx=1, busy=0, tx_done=0, tick counter s=0, bit counter n=0, shift register cleared.
- States are IDLE, START, DATA and STOP. All outputs and counters are registered and change on the same edge as the state.
- Tick counting rule: s and n advance only on cycles where tick=1. With tick=0, state, counters and tx hold.
- IDLE:
  - tx=1, busy=0.
  - On an edge with tx_start=1: load din into the shift register, set s=0, go to START, drive tx=0 and busy=1.
  - Latency from accepting edge to tx low is zero extra cycles: tx is low from that edge onward.
- START:
  - tx=0.
  - On tick with s==15: set s=0, n=0, go to DATA, drive tx=shift[0].
  - Otherwise, on tick: s=s+1.
- DATA:
  - tx=shift[0].
  - On tick with s==15: set s=0 and shift the register right by 1.
    - If n==N_BITS-1: go to STOP, drive tx=1.
    - Else: n=n+1, drive tx=next LSB.
- STOP:
  - tx=1.
  - On tick with s==SB_TICK-1: go to IDLE, tx_done=1 for exactly that one cycle, busy=0.
- Frame length is exactly 16*(1+N_BITS)+SB_TICK ticks of completed tick counts, measured from the first tick after the accepting edge.
- tx_start while busy=1 is ignored; there is no queuing and din changes after acceptance have no effect.
- Back-to-back operation: if tx_start=1 in the cycle after tx_done (state IDLE), the next frame is accepted. The minimum inter-frame gap is 1 clock of idle-high beyond the stop period.
- tick coincident with the accepting edge is not counted (state was IDLE).
- tx_done and busy are never both high.
- Reset mid-frame: on the next edge tx=1, busy=0, and no tx_done is generated for the aborted frame.
- Counters are sized so no wrap occurs:
  - s is wide enough for max(15, SB_TICK-1).
  - n is wide enough for N_BITS-1.

Test Plan:
- Reset: hold reset 2 cycles with tick toggling and tx_start=1 → tx=1, busy=0, tx_done=0 throughout. After release with tx_start=0: idle persists.
- Single frame, bench tick every 4 clocks: din=0xA5 with a 1-cycle tx_start → tx sequence 0, 1,0,1,0,0,1,0,1, 1; each level held 64 clocks (±3 for tick phase). tx_done pulses once, 640 clocks after acceptance; busy falls on the same edge.
- Busy rejection: during frame 0xA5, pulse tx_start with din=0xFF at bit 3 → serial data still 0xA5, only one tx_done, no second frame.
- Back-to-back: tx_start held high with din=0x00 then 0xFF → two frames separated by exactly 1 idle clock after tx_done. The second frame decodes as 0xFF.
- Tick stall: freeze tick low for 200 clocks mid-DATA → tx, busy and the bit position are unchanged. Resuming tick completes the frame with the correct value 0x3C.
- Reset mid-frame plus SB_TICK=32 build: reset during bit 5 → tx=1, busy=0 next edge, no tx_done. A new 0x81 frame afterwards has a stop period of 32 ticks (128 clocks).
